// File: rtl/calc_pkg.sv
// Shared types, key codes and key helpers for the calculator engine.
package calc_pkg;

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_OP_PEND,
        S_ENTRY_B,
        S_CALC,
        S_RESULT,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    localparam logic [7:0] KEY_0   = 8'h30;
    localparam logic [7:0] KEY_9   = 8'h39;
    localparam logic [7:0] KEY_ADD = 8'h2B;
    localparam logic [7:0] KEY_SUB = 8'h2D;
    localparam logic [7:0] KEY_MUL = 8'h2A;
    localparam logic [7:0] KEY_EQ  = 8'h3D;
    localparam logic [7:0] KEY_CLR = 8'h43;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= KEY_0) && (c <= KEY_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == KEY_ADD) || (c == KEY_SUB) || (c == KEY_MUL);
    endfunction

    function automatic op_t key_op(input logic [7:0] c);
        op_t o;
        case (c)
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative signed shift-add multiplier: magnitudes are multiplied over
// WIDTH cycles and the sign applied to the 2*WIDTH-bit product.
module calc_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               running;

    // The most negative operand negates to itself, which is its correct magnitude.
    assign mag_a = a[WIDTH-1] ? WIDTH'(-a) : WIDTH'(a);
    assign mag_b = b[WIDTH-1] ? WIDTH'(-b) : WIDTH'(b);
    assign product = neg ? -$signed(acc) : $signed(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{WIDTH{1'b0}}, mag_a};
                mplier  <= mag_b;
                acc     <= '0;
                cnt     <= CW'(WIDTH);
                neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Keypad-driven signed calculator FSM. Define CALC_CHAIN_EN to let an
// operator typed after the second operand evaluate and chain the result.
module calc_engine
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGITS_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_char,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] display_val,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    err
);
    localparam int CW = $clog2(DIGITS_MAX + 1);

    state_t state, state_n;
    op_t    op, op_n, pend, pend_n;
    logic   chain, chain_n;
    logic   rv_n;

    logic signed [WIDTH-1:0] a, a_n, b, b_n, entry, entry_n, disp_n;
    logic [CW-1:0]           cnt, cnt_n;

    logic                    k_dig, k_op, k_eq, k_clr;
    logic [3:0]              dval;
    logic signed [WIDTH-1:0] dext, entry_acc;
    logic signed [WIDTH:0]   sum;
    logic signed [2*WIDTH-1:0] prod;
    logic                    mul_start, mul_done;
    logic                    calc_done, calc_ovf;
    logic signed [WIDTH-1:0] calc_res;

    assign k_dig = in_valid && is_digit(in_char);
    assign k_op  = in_valid && is_op(in_char);
    assign k_eq  = in_valid && (in_char == KEY_EQ);
    assign k_clr = in_valid && (in_char == KEY_CLR);

    assign dval      = 4'(in_char - KEY_0);
    assign dext      = $signed({{(WIDTH-4){1'b0}}, dval});
    assign entry_acc = (entry <<< 3) + (entry <<< 1) + dext;

    assign sum = (op == OP_SUB) ? {a[WIDTH-1], a} - {b[WIDTH-1], b}
                                : {a[WIDTH-1], a} + {b[WIDTH-1], b};

`ifdef CALC_CHAIN_EN
    assign mul_start = (state == S_ENTRY_B) && (op == OP_MUL) && (k_eq || k_op);
`else
    assign mul_start = (state == S_ENTRY_B) && (op == OP_MUL) && k_eq;
`endif

    calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (k_clr),
        .a       (a),
        .b       (entry),
        .product (prod),
        .done    (mul_done)
    );

    // Result must survive sign-extension back from the full-precision form.
    always_comb begin
        calc_done = 1'b1;
        calc_res  = sum[WIDTH-1:0];
        calc_ovf  = sum[WIDTH] ^ sum[WIDTH-1];
        if (op == OP_MUL) begin
            calc_done = mul_done;
            calc_res  = prod[WIDTH-1:0];
            calc_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        pend_n  = pend;
        chain_n = chain;
        a_n     = a;
        b_n     = b;
        entry_n = entry;
        cnt_n   = cnt;
        disp_n  = display_val;
        rv_n    = 1'b0;
        if (k_clr) begin
            state_n = S_ENTRY_A;
            op_n    = OP_ADD;
            pend_n  = OP_ADD;
            chain_n = 1'b0;
            a_n     = '0;
            b_n     = '0;
            entry_n = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_ENTRY_A, S_ENTRY_B: begin
                    if (k_dig) begin
                        if (cnt < CW'(DIGITS_MAX)) begin
                            entry_n = entry_acc;
                            cnt_n   = cnt + CW'(1);
                        end
                    end else if (k_op && state == S_ENTRY_A) begin
                        a_n     = entry;
                        op_n    = key_op(in_char);
                        entry_n = '0;
                        cnt_n   = '0;
                        state_n = S_OP_PEND;
                    end else if (k_eq && state == S_ENTRY_B) begin
                        b_n     = entry;
                        chain_n = 1'b0;
                        state_n = S_CALC;
                    end
`ifdef CALC_CHAIN_EN
                    else if (k_op) begin
                        b_n     = entry;
                        pend_n  = key_op(in_char);
                        chain_n = 1'b1;
                        state_n = S_CALC;
                    end
`endif
                end
                S_OP_PEND: begin
                    if (k_dig) begin
                        entry_n = dext;
                        cnt_n   = CW'(1);
                        state_n = S_ENTRY_B;
                    end else if (k_op) begin
                        op_n = key_op(in_char);
                    end
                end
                S_CALC: begin
                    if (calc_done) begin
                        if (calc_ovf) begin
                            state_n = S_ERROR;
                        end else if (chain) begin
                            a_n     = calc_res;
                            op_n    = pend;
                            chain_n = 1'b0;
                            entry_n = '0;
                            cnt_n   = '0;
                            rv_n    = 1'b1;
                            state_n = S_OP_PEND;
                        end else begin
                            rv_n    = 1'b1;
                            state_n = S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    if (k_dig) begin
                        a_n     = '0;
                        entry_n = dext;
                        cnt_n   = CW'(1);
                        state_n = S_ENTRY_A;
                    end else if (k_op) begin
                        a_n     = display_val;
                        op_n    = key_op(in_char);
                        entry_n = '0;
                        cnt_n   = '0;
                        state_n = S_OP_PEND;
                    end
                end
                default: ;
            endcase
        end
        case (state_n)
            S_ENTRY_A, S_ENTRY_B: disp_n = entry_n;
            S_OP_PEND:            disp_n = a_n;
            S_RESULT:             if (state == S_CALC) disp_n = calc_res;
            S_ERROR:              disp_n = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_ENTRY_A;
            op           <= OP_ADD;
            pend         <= OP_ADD;
            chain        <= 1'b0;
            a            <= '0;
            b            <= '0;
            entry        <= '0;
            cnt          <= '0;
            display_val  <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            op           <= op_n;
            pend         <= pend_n;
            chain        <= chain_n;
            a            <= a_n;
            b            <= b_n;
            entry        <= entry_n;
            cnt          <= cnt_n;
            display_val  <= disp_n;
            result_valid <= rv_n;
        end
    end

    assign busy = (state == S_CALC);
    assign err  = (state == S_ERROR);

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, signed operand/result width in bits.
REQ-002 SHALL have parameter DIGITS_MAX, default 8, max decimal digits per entered operand; 10^DIGITS_MAX-1 SHALL fit in WIDTH-1 bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port in_char, input, 8, ASCII key code from the key-mapping stage.
REQ-006 SHALL have port in_valid, input, 1, one-cycle strobe qualifying in_char.
REQ-007 SHALL have port display_val, output, WIDTH, signed registered value to show.
REQ-008 SHALL have port result_valid, output, 1, one-cycle pulse on calculation completion.
REQ-009 SHALL have port busy, output, 1, high while in CALC.
REQ-010 SHALL have port err, output, 1, high while in ERROR.

Function
REQ-011 SHALL accept keys "0"-"9", "+", "-", "*", "=", "C"; any other code, including 0x00, SHALL be ignored.
REQ-012 SHALL implement states ENTRY_A, OP_PEND, ENTRY_B, CALC, RESULT, ERROR.
REQ-013 Digit in ENTRY_A/ENTRY_B SHALL set entry = entry*10 + d when digit count < DIGITS_MAX; otherwise ignored.
REQ-014 Digit in OP_PEND SHALL load entry = d and go to ENTRY_B; digit in RESULT SHALL load entry = d, clear operand A, and go to ENTRY_A.
REQ-015 Operator in ENTRY_A SHALL latch A = entry and op, then go to OP_PEND; operator in OP_PEND SHALL replace op only; operator in RESULT SHALL latch A = result and op, then go to OP_PEND.
REQ-016 "=" in ENTRY_B SHALL latch B = entry and go to CALC; "=" in any other state SHALL be ignored.
REQ-017 "C" in any state, including CALC, SHALL clear A, B, entry, op, and digit count, abort any multiply, and go to ENTRY_A next edge with no result_valid.
REQ-018 Keys other than "C" during CALC or ERROR SHALL be ignored.
REQ-019 Add/sub SHALL complete one edge after entering CALC; multiply SHALL complete WIDTH+1 edges after entering CALC.
REQ-020 On completion result_valid SHALL pulse one cycle, with display_val updated on the same edge.
REQ-021 Arithmetic SHALL be signed two's complement with full-precision overflow detection (WIDTH+1 bits for add/sub, 2*WIDTH bits for multiply).
REQ-022 Overflow SHALL transition to ERROR with display_val = 0, err = 1, and no result_valid.
REQ-023 display_val SHALL equal entry in ENTRY_A/ENTRY_B, A in OP_PEND, the held value in CALC, the result in RESULT, and 0 in ERROR.
REQ-024 Only "C" SHALL leave ERROR.

Reset
REQ-025 On rst_n low SHALL force ENTRY_A, display_val = 0, result_valid = 0, busy = 0, err = 0, and clear all operand registers, asynchronously.

Configuration
REQ-026 With CALC_CHAIN_EN defined, an operator in ENTRY_B SHALL latch B, compute A op B via CALC, then set A = result and the new op, and go to OP_PEND; result_valid SHALL pulse.
REQ-027 Without CALC_CHAIN_EN, an operator in ENTRY_B SHALL be ignored.

Structure
REQ-028 Package calc_pkg SHALL hold the state enum, the op enum (ADD/SUB/MUL), ASCII key constants, and the is_digit helper.
REQ-029 Multiply SHALL be sub-module calc_mul_seq: iterative shift-add, start/done handshake, abort input, 2*WIDTH product, WIDTH iteration cycles.

Verification
REQ-030 "1","2","+","3","=" -> display_val 15, one result_valid pulse, state RESULT.
REQ-031 "9","9","9","*","9","9","9","=" -> busy high WIDTH+1 cycles, then display_val 998001.
REQ-032 "5","-","8","=" then "*","2","=" -> display_val -3, then -6.
REQ-033 "99999999","*","99999999","=" -> err 1, display_val 0; "+" ignored; "C" -> err 0, display_val 0.
REQ-034 "C" pulsed on the third cycle of a multiply -> busy low next edge, display_val 0, no result_valid.
REQ-035 "2","+","3","*","4","=" -> 20 with CALC_CHAIN_EN; 36 without. Nine digits "123456789" -> display_val 12345678.
